event_rate_meter: RTL and testbench

EVENT_RATE_METER -- requirements
Module: event_rate_meter

---
 rtl/event_rate_meter_pkg.sv | 24 ++
 rtl/rate_channel_counter.sv | 60 ++++++
 rtl/event_rate_meter.sv | 109 ++++++++++
 tb/tb_event_rate_meter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_rate_meter_pkg.sv
// rtl/event_rate_meter_pkg.sv - shared states, digit constant and sizing helper for the event rate meter
package event_rate_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meterState_t;

  localparam logic [3:0] DigitMax = 4'd9;

  // Bits needed to hold value-1, i.e. the largest window counter value.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rate_channel_counter.sv
// rtl/rate_channel_counter.sv - saturating BCD/binary live event counter for one channel
module rate_channel_counter
  import event_rate_meter_pkg::*;
#(
  parameter int CountDigits = 6,
  parameter int BcdMode     = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     increment,
  output logic [4*CountDigits-1:0] countNext,
  output logic                     overflowNext
);

  localparam int CountWidth = 4 * CountDigits;
  localparam logic [CountWidth-1:0] MaxValue =
      (BcdMode != 0) ? {CountDigits{DigitMax}} : {CountWidth{1'b1}};

  logic [CountWidth-1:0] count;
  logic                  overflow;
  logic [CountWidth-1:0] bcdSum;
  logic                  carry;

  // Ripple a +1 through the decimal digits, wrapping 9 to 0 with carry.
  always_comb begin
    bcdSum = count;
    carry  = 1'b1;
    for (int d = 0; d < CountDigits; d++) begin
      if (carry) begin
        if (count[4*d +: 4] == DigitMax) begin
          bcdSum[4*d +: 4] = 4'd0;
        end else begin
          bcdSum[4*d +: 4] = count[4*d +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // countNext includes this cycle's event so a window-ending tick can latch it.
  always_comb begin
    countNext = count;
    if (increment && (count != MaxValue)) begin
      countNext = (BcdMode != 0) ? bcdSum : count + CountWidth'(1);
    end
    overflowNext = overflow | (countNext == MaxValue);
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count    <= countNext;
      overflow <= overflowNext;
    end
  end

endmodule

// File: rtl/event_rate_meter.sv
// rtl/event_rate_meter.sv - per-channel event counts over fixed windows with latched readout
module event_rate_meter
  import event_rate_meter_pkg::*;
#(
  parameter int NumberOfChannels = 4,
  parameter int WindowCycles     = 12000,
  parameter int CountDigits      = 6,
  parameter int BcdMode          = 1
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    enable,
  input  logic [NumberOfChannels-1:0]             events,
  input  logic [2:0]                              channelSelect,
  output logic [NumberOfChannels*4*CountDigits-1:0] results,
  output logic [NumberOfChannels-1:0]             overflow,
  output logic                                    resultValid,
  output logic                                    measured,
  output logic [31:0]                             selectedValue
);

  localparam int CountWidth  = 4 * CountDigits;
  localparam int WindowWidth = clog2(WindowCycles);
  localparam logic [WindowWidth-1:0] WindowReload = WindowWidth'(WindowCycles - 1);

  meterState_t                            state;
  meterState_t                            stateNext;
  logic                                   active;
  logic                                   tick;
  logic [WindowWidth-1:0]                 windowCount;
  logic [NumberOfChannels*CountWidth-1:0] liveNext;
  logic [NumberOfChannels-1:0]            liveOverflowNext;
  logic [31:0]                            channelWide [NumberOfChannels];
  logic [31:0]                            selectNext;

  always_comb begin
    stateNext = state;
    active    = 1'b0;
    tick      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) stateNext = MEASURE;
      end
      MEASURE: begin
        if (!enable) stateNext = IDLE;
        active = enable;
        tick   = enable && (windowCount == '0);
      end
      default: stateNext = IDLE;
    endcase
  end

  for (genvar c = 0; c < NumberOfChannels; c++) begin : gChannel
    rate_channel_counter #(
      .CountDigits(CountDigits),
      .BcdMode    (BcdMode)
    ) uCounter (
      .clock       (clock),
      .reset       (reset),
      .clear       (tick || !active),
      .increment   (active && events[c]),
      .countNext   (liveNext[c*CountWidth +: CountWidth]),
      .overflowNext(liveOverflowNext[c])
    );

    if (CountWidth >= 32) begin : gWide
      assign channelWide[c] = results[c*CountWidth +: 32];
    end else begin : gNarrow
      assign channelWide[c] = {{(32-CountWidth){1'b0}}, results[c*CountWidth +: CountWidth]};
    end
  end

  // Indices with no channel behind them fall through to zero.
  always_comb begin
    selectNext = '0;
    for (int c = 0; c < NumberOfChannels; c++) begin
      if (channelSelect == 3'(c)) selectNext = channelWide[c];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      windowCount   <= WindowReload;
      results       <= '0;
      overflow      <= '0;
      resultValid   <= 1'b0;
      measured      <= 1'b0;
      selectedValue <= '0;
    end else begin
      state         <= stateNext;
      selectedValue <= selectNext;
      resultValid   <= tick;
      if (!active || tick) begin
        windowCount <= WindowReload;
      end else begin
        windowCount <= windowCount - WindowWidth'(1);
      end
      if (tick) begin
        results  <= liveNext;
        overflow <= liveOverflowNext;
        measured <= 1'b1;
      end else if (!active) begin
        measured <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_event_rate_meter.sv
// tb/tb_event_rate_meter.sv - randomized and directed bench for event_rate_meter over three configurations
module tb_event_rate_meter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  events = 4'h0;
  logic [2:0]  channelSelect = 3'd0;

  logic [31:0] resultsA;
  logic [15:0] resultsB, resultsC;
  logic [3:0]  overflowA, overflowB, overflowC;
  logic        validA, validB, validC;
  logic        measuredA, measuredB, measuredC;
  logic [31:0] selectA, selectB, selectC;

  int assertionCount = 0;
  int failCount = 0;

  always #5 clock = ~clock;

  event_rate_meter #(.NumberOfChannels(4), .WindowCycles(10), .CountDigits(2), .BcdMode(1)) dutA (
    .clock(clock), .reset(reset), .enable(enable), .events(events), .channelSelect(channelSelect),
    .results(resultsA), .overflow(overflowA), .resultValid(validA), .measured(measuredA),
    .selectedValue(selectA));

  event_rate_meter #(.NumberOfChannels(4), .WindowCycles(20), .CountDigits(1), .BcdMode(1)) dutB (
    .clock(clock), .reset(reset), .enable(enable), .events(events), .channelSelect(channelSelect),
    .results(resultsB), .overflow(overflowB), .resultValid(validB), .measured(measuredB),
    .selectedValue(selectB));

  event_rate_meter #(.NumberOfChannels(4), .WindowCycles(20), .CountDigits(1), .BcdMode(0)) dutC (
    .clock(clock), .reset(reset), .enable(enable), .events(events), .channelSelect(channelSelect),
    .results(resultsC), .overflow(overflowC), .resultValid(validC), .measured(measuredC),
    .selectedValue(selectC));

  logic [31:0] actRes [3];
  logic [3:0]  actOv [3];
  logic        actValid [3];
  logic        actMeas [3];
  logic [31:0] actSel [3];

  assign actRes[0] = resultsA;
  assign actRes[1] = {16'h0, resultsB};
  assign actRes[2] = {16'h0, resultsC};
  assign actOv[0] = overflowA;
  assign actOv[1] = overflowB;
  assign actOv[2] = overflowC;
  assign actValid[0] = validA;
  assign actValid[1] = validB;
  assign actValid[2] = validC;
  assign actMeas[0] = measuredA;
  assign actMeas[1] = measuredB;
  assign actMeas[2] = measuredC;
  assign actSel[0] = selectA;
  assign actSel[1] = selectB;
  assign actSel[2] = selectC;

  function automatic int winOf(input int d);
    return (d == 0) ? 10 : 20;
  endfunction

  function automatic int digitsOf(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic bit bcdOf(input int d);
    return d != 2;
  endfunction

  function automatic int maxCount(input int d);
    int m;
    m = 1;
    for (int i = 0; i < digitsOf(d); i++) m = m * (bcdOf(d) ? 10 : 16);
    return m - 1;
  endfunction

  function automatic logic [31:0] encode(input int n, input int d);
    int m;
    logic [31:0] r;
    m = (n > maxCount(d)) ? maxCount(d) : n;
    if (!bcdOf(d)) return 32'(m);
    r = '0;
    for (int i = 0; i < digitsOf(d); i++) begin
      r = r | (32'(m % 10) << (4 * i));
      m = m / 10;
    end
    return r;
  endfunction

  // Reference model: integer event tallies per window, saturation applied at encode time.
  bit          modelReady = 1'b0;
  bit          mMeasuring;
  int          mPhase [3];
  int          mLive [3][4];
  logic [31:0] expCh [3][4];
  bit          expOv [3][4];
  bit          expValid [3];
  bit          expMeasured [3];
  logic [31:0] expSel [3];

  function automatic logic [31:0] packRes(input int d);
    logic [31:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) r = r | (expCh[d][c] << (c * 4 * digitsOf(d)));
    return r;
  endfunction

  function automatic logic [3:0] packOv(input int d);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = expOv[d][c];
    return r;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      mMeasuring = 1'b0;
      for (int d = 0; d < 3; d++) begin
        mPhase[d] = 0;
        expValid[d] = 1'b0;
        expMeasured[d] = 1'b0;
        expSel[d] = '0;
        for (int c = 0; c < 4; c++) begin
          mLive[d][c] = 0;
          expCh[d][c] = '0;
          expOv[d][c] = 1'b0;
        end
      end
      modelReady = 1'b1;
    end else begin
      for (int d = 0; d < 3; d++) begin
        expSel[d] = (channelSelect < 3'd4) ? expCh[d][channelSelect[1:0]] : 32'h0;
        expValid[d] = 1'b0;
        if (mMeasuring && enable) begin
          mPhase[d] = mPhase[d] + 1;
          for (int c = 0; c < 4; c++) if (events[c]) mLive[d][c] = mLive[d][c] + 1;
          if (mPhase[d] == winOf(d)) begin
            for (int c = 0; c < 4; c++) begin
              expCh[d][c] = encode(mLive[d][c], d);
              expOv[d][c] = mLive[d][c] >= maxCount(d);
              mLive[d][c] = 0;
            end
            mPhase[d] = 0;
            expValid[d] = 1'b1;
            expMeasured[d] = 1'b1;
          end
        end else begin
          mPhase[d] = 0;
          for (int c = 0; c < 4; c++) mLive[d][c] = 0;
          expMeasured[d] = 1'b0;
        end
      end
      mMeasuring = enable;
    end
  end

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    assertionCount++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s dut%0d at %0t: got %h expected %h", name, d, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (modelReady) begin
      for (int d = 0; d < 3; d++) begin
        check("results", d, actRes[d], packRes(d));
        check("overflow", d, 32'(actOv[d]), 32'(packOv(d)));
        check("resultValid", d, 32'(actValid[d]), 32'(expValid[d]));
        check("measured", d, 32'(actMeas[d]), 32'(expMeasured[d]));
        check("selectedValue", d, actSel[d], expSel[d]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic startMeasure();
    enable = 1'b0;
    step(1);
    enable = 1'b1;
    step(1);
  endtask

  logic [31:0] selectTable [8];
  int cyclesToValid;
  bit found;

  initial begin
    selectTable = '{32'h02, 32'h04, 32'h06, 32'h08, 32'h0, 32'h0, 32'h0, 32'h0};
    step(2);
    reset = 1'b0;
    check("resetResults", 0, resultsA, 32'h0);
    check("resetMeasured", 0, 32'(measuredA), 32'h0);
    step(1);

    // Seven strobes on channel 0 in the first window.
    startMeasure();
    for (int i = 0; i < 10; i++) begin
      events = (i < 7) ? 4'b0001 : 4'b0000;
      step(1);
    end
    events = 4'h0;
    check("ch0Seven", 0, 32'(resultsA[7:0]), 32'h07);
    check("validPulse", 0, 32'(validA), 32'h1);
    check("measuredSet", 0, 32'(measuredA), 32'h1);
    step(1);
    check("validDrops", 0, 32'(validA), 32'h0);

    // Channel 1 strobed continuously across three windows.
    startMeasure();
    events = 4'b0010;
    step(30);
    check("ch1Ten", 0, 32'(resultsA[15:8]), 32'h10);
    check("ch1NoOverflow", 0, 32'(overflowA[1]), 32'h0);
    events = 4'h0;

    // Single BCD digit saturates, then recovers next window.
    startMeasure();
    for (int i = 0; i < 20; i++) begin
      events = (i < 12) ? 4'b0100 : 4'b0000;
      step(1);
    end
    check("bcdSaturate", 1, 32'(resultsB[11:8]), 32'h9);
    check("bcdOverflow", 1, 32'(overflowB[2]), 32'h1);
    for (int i = 0; i < 20; i++) begin
      events = (i < 2) ? 4'b0100 : 4'b0000;
      step(1);
    end
    check("bcdRecover", 1, 32'(resultsB[11:8]), 32'h2);
    check("bcdOverflowClear", 1, 32'(overflowB[2]), 32'h0);

    // Binary digit: 15 reaches the maximum, 14 does not.
    startMeasure();
    for (int i = 0; i < 20; i++) begin
      events = (i < 15) ? 4'b0100 : 4'b0000;
      step(1);
    end
    check("binMax", 2, 32'(resultsC[11:8]), 32'hF);
    check("binOverflow", 2, 32'(overflowC[2]), 32'h1);
    for (int i = 0; i < 20; i++) begin
      events = (i < 14) ? 4'b0100 : 4'b0000;
      step(1);
    end
    check("binFourteen", 2, 32'(resultsC[11:8]), 32'hE);
    check("binOverflowClear", 2, 32'(overflowC[2]), 32'h0);

    // Distinct counts per channel, then step the readout index.
    startMeasure();
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 4; c++) events[c] = (i < 2 * (c + 1));
      step(1);
    end
    enable = 1'b0;
    events = 4'h0;
    for (int s = 0; s < 8; s++) begin
      channelSelect = 3'(s);
      step(1);
      check("selectStep", 0, selectA, selectTable[s]);
    end

    // Reset in the fifth cycle of a window holding three counts.
    startMeasure();
    for (int i = 0; i < 4; i++) begin
      events = (i < 3) ? 4'b0001 : 4'b0000;
      step(1);
    end
    reset = 1'b1;
    events = 4'h0;
    step(1);
    check("midResetResults", 0, resultsA, 32'h0);
    check("midResetOverflow", 0, 32'(overflowA), 32'h0);
    check("midResetValid", 0, 32'(validA), 32'h0);
    check("midResetMeasured", 0, 32'(measuredA), 32'h0);
    check("midResetSelect", 0, selectA, 32'h0);
    reset = 1'b0;
    cyclesToValid = 0;
    found = 1'b0;
    for (int k = 1; k <= 30 && !found; k++) begin
      step(1);
      if (validA) begin
        found = 1'b1;
        cyclesToValid = k;
      end
    end
    check("validAfterReset", 0, 32'(cyclesToValid), 32'd11);

    // Randomized traffic with occasional enable toggles and resets.
    enable = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      events = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) events[3] = 1'b1;
      channelSelect = 3'($urandom_range(0, 7));
      step(1);
    end
    reset = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failCount);
    $finish;
  end

endmodule
